// File: rtl/page_reg_pkg.sv
// page_reg_pkg: constants and types shared by the page register arbiter.
//   DEF_NREQ / DEF_WIDTH / DEF_AW : default requester count, data width and
//                                   page-select width.
//   state_t                       : arbiter FSM state encoding. The same
//                                   encoding appears on the state_dbg port.
package page_reg_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/page_reg_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req   [NREQ-1:0] : request vector
//   ptr   [IW-1:0]   : index of the last winner; the search starts at ptr+1
//   grant [NREQ-1:0] : one-hot winner, all zero when no request
//   idx   [IW-1:0]   : binary index of the winner
//   any              : at least one request is set
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int cand;

    // Walk offsets 1..NREQ from the last winner so the last winner itself is
    // visited last; the first request found on that walk wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/page_reg_arbiter.sv
// page_reg_arbiter: shares one page register bank between NREQ requesters.
//   clk, reset_n        : clock, asynchronous active-low reset
//   req/wr/addr/wdata   : per-requester request, direction (1 = write),
//                         page index and write data (packed, requester i at
//                         [i*AW +: AW] / [i*WIDTH +: WIDTH])
//   gnt                 : one-hot, one-cycle grant per accepted transaction
//   rvalid/rdata/rid    : read result pulse, data and owning requester
//   en_in/en_out        : bank write / read enable
//   page_sel/bank_in    : bank entry index and write data (hold last value)
//   bank_out            : bank read data, valid the cycle after en_out
//   state_dbg           : current FSM state (page_reg_pkg::state_t encoding)
//
// Handshake: a requester holds req high until it sees its own gnt bit. gnt
// is the acceptance; a req still high in the cycle after gnt is a new
// transaction. Requests are only sampled in IDLE, so a req that rises and
// falls while a transaction is in flight is never seen.
module page_reg_arbiter
    import page_reg_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    rvalid,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(NREQ)-1:0] rid,
    output logic                    en_in,
    output logic                    en_out,
    output logic [AW-1:0]           page_sel,
    output logic [WIDTH-1:0]        bank_in,
    input  logic [WIDTH-1:0]        bank_out,
    output logic [1:0]              state_dbg
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur_id;
    logic            cur_wr;

    logic [NREQ-1:0] win_grant;
    logic [IW-1:0]   win_idx;
    logic            win_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign state_dbg = state;

    // Every output is registered: the access strobes are loaded on the edge
    // that leaves IDLE so they are visible during the ACCESS cycle, and the
    // read result is loaded on the edge that leaves CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ptr      <= IW'(NREQ - 1);
            cur_id   <= '0;
            cur_wr   <= 1'b0;
            gnt      <= '0;
            en_in    <= 1'b0;
            en_out   <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rid      <= '0;
            page_sel <= '0;
            bank_in  <= '0;
        end else begin
            gnt    <= '0;
            en_in  <= 1'b0;
            en_out <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        ptr      <= win_idx;
                        cur_id   <= win_idx;
                        cur_wr   <= wr[win_idx];
                        gnt      <= win_grant;
                        page_sel <= addr[win_idx*AW +: AW];
                        if (wr[win_idx]) begin
                            en_in   <= 1'b1;
                            bank_in <= wdata[win_idx*WIDTH +: WIDTH];
                        end else begin
                            en_out  <= 1'b1;
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= cur_wr ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // bank_out answers the en_out issued in ACCESS.
                    rdata  <= bank_out;
                    rvalid <= 1'b1;
                    rid    <= cur_id;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/page_reg_arbiter.md
PAGE_REG_ARBITER -- requirements
Module: page_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one MUX_REG_8x8 page register bank.
REQ-002 Parameter WIDTH, default 8, data width of one page entry.
REQ-003 Parameter AW, default 3, page-select width (2**AW = 8 entries).
REQ-004 Port clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port req  input  NREQ  per-requester transaction request, level, held until own gnt.
REQ-007 Port wr  input  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-008 Port addr  input  NREQ*AW  per-requester page index, requester i at [i*AW +: AW].
REQ-009 Port wdata  input  NREQ*WIDTH  per-requester write data, requester i at [i*WIDTH +: WIDTH].
REQ-010 Port gnt  output  NREQ  one-hot grant pulse, one cycle per accepted transaction.
REQ-011 Port rvalid  output  1  read-data valid pulse.
REQ-012 Port rdata  output  WIDTH  read data, valid with rvalid.
REQ-013 Port rid  output  $clog2(NREQ)  index of requester owning rdata.
REQ-014 Port en_in  output  1  bank write enable.
REQ-015 Port en_out  output  1  bank read enable.
REQ-016 Port page_sel  output  AW  bank entry index.
REQ-017 Port bank_in  output  WIDTH  bank write data.
REQ-018 Port bank_out  input  WIDTH  bank read data, valid the cycle after en_out.

Function
REQ-019 FSM states IDLE, ACCESS, CAPTURE; all outputs registered.
REQ-020 IDLE with any req bit set: round-robin pick winner w, latch wr[w]/addr[w]/wdata[w]/w, go ACCESS; no req: stay IDLE.
REQ-021 ACCESS (one cycle): gnt[w]=1; page_sel=latched addr; write -> en_in=1, bank_in=latched wdata, next IDLE; read -> en_out=1, next CAPTURE.
REQ-022 CAPTURE (one cycle): sample bank_out; next cycle rvalid=1, rdata=sample, rid=w, state IDLE.
REQ-023 Latency: req sampled in IDLE at cycle T -> gnt/en_in/en_out at T+1; read rvalid at T+3.
REQ-024 Throughput: write every 2 cycles, read every 3; IDLE may arbitrate in the same cycle rvalid is high.
REQ-025 Round-robin: search starts at last winner +1, wraps NREQ-1 -> 0; pointer updates only on a grant.
REQ-026 Requester i waits at most NREQ-1 other grants while req[i] stays high (no starvation).
REQ-027 req[i] dropped before grant: no grant, no bank access, pointer unchanged.
REQ-028 req[i] still high the cycle after its gnt is a new transaction, arbitrated normally.
REQ-029 Inputs changing during ACCESS/CAPTURE do not affect the in-flight transaction.
REQ-030 en_in and en_out never high together; gnt at most one bit set.
REQ-031 Outputs not named active in the current state are 0 (page_sel, bank_in hold last value).

Reset
REQ-032 reset_n low: state IDLE, gnt=0, en_in=0, en_out=0, rvalid=0, rdata=0, rid=0, page_sel=0, bank_in=0, pointer = NREQ-1 (requester 0 highest after reset).
REQ-033 Reset asserted mid-transaction aborts it: no further en_in/en_out/gnt/rvalid for it.
REQ-034 First arbitration occurs on the first clk edge after reset_n deasserts with req set.

Structure
REQ-035 Package page_reg_pkg holds FSM state enum and default NREQ/WIDTH/AW constants.
REQ-036 Round-robin selection in sub-module rr_arbiter (req, pointer in; one-hot winner, index out), combinational.

Verification
REQ-037 req=4'b0001 wr=1 addr0=5 wdata0=8'hA5 -> T+1 gnt=0001, en_in=1, page_sel=5, bank_in=A5.
REQ-038 Bank model holding 8'h3C at entry 2; req=4'b0100 wr=0 addr2=2 -> T+1 en_out=1, T+3 rvalid=1, rdata=3C, rid=2.
REQ-039 req=4'b1111 held, all writes -> grant order 0,1,2,3,0 at 2-cycle spacing.
REQ-040 Last winner 3, req=4'b1001 -> next grant requester 0 (wrap).
REQ-041 reset_n low during CAPTURE of a read -> rvalid never asserts; after release req=0001 granted at T+1.
REQ-042 req=0010 raised then dropped same cycle state is ACCESS -> no grant to requester 1, pointer unchanged.
